// File: rtl/operand_sequencer_3x16.sv
// ---------------------------------------------------------------------------
// operand_sequencer_3x16
//
// Loads three 16-bit operand words and then presents them one at a time
// through a downstream 3:1 selector stage.
//
// Sequence of operation:
//   LOAD  Words are accepted on every edge where Load=1 (Ready is high).
//         They fill REG1, REG2, REG3 in that order.
//   SEND  The FSM steps Selector through 0, 1, 2 with Enable high.
//         Each selector value is held for DWELL un-held cycles.
//   DONE  Done pulses for one cycle, then the FSM returns to LOAD.
//
// Ports:
//   clk         sole clock; all state changes on the rising edge
//   reset       synchronous, active-high; clears all state, including the
//               operand registers
//   Data_In     operand word offered for loading
//   Load        Data_In valid; the word is taken when Load=1 and Ready=1
//   Clear       synchronous abort back to LOAD with word count 0; the
//               operand registers keep their contents
//   Hold        downstream stall; freezes sequencing in SEND only
//   Ready       high only in LOAD
//   REG1..REG3  registered operand words 0..2
//   Selector    registered index of the operand currently presented
//   Enable      registered; high only in SEND
//   Done        registered one-cycle pulse after the last operand
//   Count       number of words accepted in the current load (0..3)
// ---------------------------------------------------------------------------
module operand_sequencer_3x16 #(
    parameter int DWELL = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Data_In,
    input  logic        Load,
    input  logic        Clear,
    input  logic        Hold,
    output logic        Ready,
    output logic [15:0] REG1,
    output logic [15:0] REG2,
    output logic [15:0] REG3,
    output logic [1:0]  Selector,
    output logic        Enable,
    output logic        Done,
    output logic [1:0]  Count
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Dwell counter value on the last cycle of a selector's dwell.
    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    state_t      state_q, state_d;
    logic [15:0] reg1_q, reg1_d;
    logic [15:0] reg2_q, reg2_d;
    logic [15:0] reg3_q, reg3_d;
    logic [1:0]  sel_q, sel_d;
    logic        en_q, en_d;
    logic        done_q, done_d;
    logic [1:0]  count_q, count_d;
    logic [3:0]  dwell_q, dwell_d;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        reg1_d  = reg1_q;
        reg2_d  = reg2_q;
        reg3_d  = reg3_q;
        sel_d   = sel_q;
        en_d    = en_q;
        done_d  = done_q;
        count_d = count_q;
        dwell_d = dwell_q;

        if (Clear) begin
            // Abort: operand registers are deliberately left untouched.
            state_d = ST_LOAD;
            sel_d   = 2'd0;
            en_d    = 1'b0;
            done_d  = 1'b0;
            count_d = 2'd0;
            dwell_d = 4'd0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    // Count never reaches 3 in LOAD, but guard it so a stray
                    // value can not write past REG3.
                    if (Load && (count_q != 2'd3)) begin
                        count_d = count_q + 2'd1;
                        case (count_q)
                            2'd0:    reg1_d = Data_In;
                            2'd1:    reg2_d = Data_In;
                            default: begin
                                reg3_d  = Data_In;
                                state_d = ST_SEND;
                                sel_d   = 2'd0;
                                en_d    = 1'b1;
                                dwell_d = 4'd0;
                            end
                        endcase
                    end
                end

                ST_SEND: begin
                    if (!Hold) begin
                        if (dwell_q == DWELL_LAST) begin
                            dwell_d = 4'd0;
                            if (sel_q == 2'd2) begin
                                state_d = ST_DONE;
                                sel_d   = 2'd0;
                                en_d    = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                sel_d = sel_q + 2'd1;
                            end
                        end else begin
                            dwell_d = dwell_q + 4'd1;
                        end
                    end
                end

                ST_DONE: begin
                    state_d = ST_LOAD;
                    done_d  = 1'b0;
                    count_d = 2'd0;
                end

                default: begin
                    state_d = ST_LOAD;
                    sel_d   = 2'd0;
                    en_d    = 1'b0;
                    done_d  = 1'b0;
                    count_d = 2'd0;
                    dwell_d = 4'd0;
                end
            endcase
        end
    end

    // State register; reset overrides Clear, Load and Hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
            reg1_q  <= 16'h0000;
            reg2_q  <= 16'h0000;
            reg3_q  <= 16'h0000;
            sel_q   <= 2'd0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            count_q <= 2'd0;
            dwell_q <= 4'd0;
        end else begin
            state_q <= state_d;
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            reg3_q  <= reg3_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            done_q  <= done_d;
            count_q <= count_d;
            dwell_q <= dwell_d;
        end
    end

    assign Ready    = (state_q == ST_LOAD);
    assign REG1     = reg1_q;
    assign REG2     = reg2_q;
    assign REG3     = reg3_q;
    assign Selector = sel_q;
    assign Enable   = en_q;
    assign Done     = done_q;
    assign Count    = count_q;

endmodule

// File: tb/tb_operand_sequencer_3x16.sv
// ---------------------------------------------------------------------------
// tb_operand_sequencer_3x16
//
// Two instances share one set of inputs: one with DWELL=1 and one with
// DWELL=3. The outputs of the instance under test are selected by use3.
// A scoreboard holds one entry {selector, word} for every cycle in which
// Enable is expected high; the monitor pops one entry per Enable cycle.
// ---------------------------------------------------------------------------
module tb_operand_sequencer_3x16;

    logic        clk;
    logic        reset;
    logic [15:0] Data_In;
    logic        Load;
    logic        Clear;
    logic        Hold;

    logic        ready1, en1, done1, ready3, en3, done3;
    logic [15:0] r1_1, r2_1, r3_1, r1_3, r2_3, r3_3;
    logic [1:0]  sel1, cnt1, sel3, cnt3;

    operand_sequencer_3x16 #(.DWELL(1)) dut1 (
        .clk(clk), .reset(reset), .Data_In(Data_In), .Load(Load),
        .Clear(Clear), .Hold(Hold), .Ready(ready1), .REG1(r1_1),
        .REG2(r2_1), .REG3(r3_1), .Selector(sel1), .Enable(en1),
        .Done(done1), .Count(cnt1)
    );

    operand_sequencer_3x16 #(.DWELL(3)) dut3 (
        .clk(clk), .reset(reset), .Data_In(Data_In), .Load(Load),
        .Clear(Clear), .Hold(Hold), .Ready(ready3), .REG1(r1_3),
        .REG2(r2_3), .REG3(r3_3), .Selector(sel3), .Enable(en3),
        .Done(done3), .Count(cnt3)
    );

    logic        use3;
    logic        o_ready, o_en, o_done;
    logic [15:0] o_r1, o_r2, o_r3, o_word;
    logic [1:0]  o_sel, o_cnt;

    assign o_ready = use3 ? ready3 : ready1;
    assign o_en    = use3 ? en3    : en1;
    assign o_done  = use3 ? done3  : done1;
    assign o_r1    = use3 ? r1_3   : r1_1;
    assign o_r2    = use3 ? r2_3   : r2_1;
    assign o_r3    = use3 ? r3_3   : r3_1;
    assign o_sel   = use3 ? sel3   : sel1;
    assign o_cnt   = use3 ? cnt3   : cnt1;
    assign o_word  = (o_sel == 2'd0) ? o_r1 : (o_sel == 2'd1) ? o_r2 : o_r3;

    int n_checks = 0;
    int n_fails  = 0;
    int done_cnt = 0;
    logic [17:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pop, selector range and Done pulse counting.
    always @(negedge clk) begin
        logic [17:0] e;
        chk_eq("sel_range", 32'(o_sel == 2'd3), 32'd0);
        if (o_done) done_cnt++;
        if (o_en) begin
            if (exp_q.size() == 0) begin
                chk_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk_eq("sb_sel", 32'(o_sel), 32'(e[17:16]));
                chk_eq("sb_word", 32'(o_word), 32'(e[15:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input logic [1:0] s, input logic [15:0] w, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({s, w});
    endtask

    task automatic push_seq(input int dw, input logic [15:0] a, b, c);
        push_n(2'd0, a, dw);
        push_n(2'd1, b, dw);
        push_n(2'd2, c, dw);
    endtask

    task automatic do_reset();
        reset = 1'b1; Load = 1'b0; Clear = 1'b0; Hold = 1'b0; Data_In = 16'h0;
        tick();
        reset = 1'b0;
    endtask

    task automatic load3(input logic [15:0] a, b, c, input bit keep);
        Load = 1'b1; Data_In = a;
        tick();
        chk_eq("ld_cnt1", 32'(o_cnt), 32'd1);
        chk_eq("ld_reg1", 32'(o_r1), 32'(a));
        Data_In = b;
        tick();
        chk_eq("ld_cnt2", 32'(o_cnt), 32'd2);
        chk_eq("ld_reg2", 32'(o_r2), 32'(b));
        Data_In = c;
        tick();
        chk_eq("ld_cnt3", 32'(o_cnt), 32'd3);
        chk_eq("ld_reg3", 32'(o_r3), 32'(c));
        chk_eq("send_ready", 32'(o_ready), 32'd0);
        chk_eq("send_en", 32'(o_en), 32'd1);
        chk_eq("send_sel0", 32'(o_sel), 32'd0);
        if (keep) Data_In = 16'hFFFF;
        else Load = 1'b0;
    endtask

    initial begin
        int d0;
        int en_cnt;
        use3 = 1'b0;
        reset = 1'b1; Load = 1'b0; Clear = 1'b0; Hold = 1'b0; Data_In = 16'h0;

        // Basic sequence, DWELL=1
        do_reset();
        use3 = 1'b0;
        chk_eq("rst_ready", 32'(o_ready), 32'd1);
        chk_eq("rst_cnt", 32'(o_cnt), 32'd0);
        chk_eq("rst_sel", 32'(o_sel), 32'd0);
        chk_eq("rst_en", 32'(o_en), 32'd0);
        chk_eq("rst_done", 32'(o_done), 32'd0);
        chk_eq("rst_regs", {16'h0, o_r1 | o_r2 | o_r3}, 32'd0);
        d0 = done_cnt;
        push_seq(1, 16'h1111, 16'h2222, 16'h3333);
        load3(16'h1111, 16'h2222, 16'h3333, 1'b0);
        tick();
        chk_eq("d1_sel1", 32'(o_sel), 32'd1);
        tick();
        chk_eq("d1_sel2", 32'(o_sel), 32'd2);
        tick();
        chk_eq("d1_done", 32'(o_done), 32'd1);
        chk_eq("d1_done_en", 32'(o_en), 32'd0);
        chk_eq("d1_done_sel", 32'(o_sel), 32'd0);
        tick();
        chk_eq("d1_ready", 32'(o_ready), 32'd1);
        chk_eq("d1_cnt0", 32'(o_cnt), 32'd0);
        chk_eq("d1_done_off", 32'(o_done), 32'd0);
        chk_eq("d1_pulses", 32'(done_cnt - d0), 32'd1);

        // DWELL=3: nine Enable cycles and one Done pulse
        do_reset();
        use3 = 1'b1;
        d0 = done_cnt;
        en_cnt = 0;
        push_seq(3, 16'h1111, 16'h2222, 16'h3333);
        load3(16'h1111, 16'h2222, 16'h3333, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (o_en) en_cnt++;
            if (i == 3) chk_eq("d3_sel_c3", 32'(o_sel), 32'd1);
            if (i == 9) chk_eq("d3_done", 32'(o_done), 32'd1);
            tick();
        end
        chk_eq("d3_en_cycles", 32'(en_cnt), 32'd9);
        chk_eq("d3_pulses", 32'(done_cnt - d0), 32'd1);
        chk_eq("d3_ready", 32'(o_ready), 32'd1);

        // Hold for 4 cycles during Selector=1 (DWELL=3)
        do_reset();
        use3 = 1'b1;
        push_n(2'd0, 16'hA001, 3);
        push_n(2'd1, 16'hA002, 7);
        push_n(2'd2, 16'hA003, 3);
        load3(16'hA001, 16'hA002, 16'hA003, 1'b0);
        repeat (4) tick();
        Hold = 1'b1;
        chk_eq("hold_sel_pre", 32'(o_sel), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_eq("hold_sel", 32'(o_sel), 32'd1);
            chk_eq("hold_en", 32'(o_en), 32'd1);
        end
        Hold = 1'b0;
        tick();
        chk_eq("hold_resume_sel1", 32'(o_sel), 32'd1);
        tick();
        chk_eq("hold_resume_sel2", 32'(o_sel), 32'd2);
        repeat (3) tick();
        chk_eq("hold_done", 32'(o_done), 32'd1);
        tick();

        // Load held high through SEND with Data_In=FFFF (DWELL=1)
        do_reset();
        use3 = 1'b0;
        push_seq(1, 16'h1111, 16'h2222, 16'h3333);
        load3(16'h1111, 16'h2222, 16'h3333, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk_eq("lds_cnt", 32'(o_cnt), 32'd3);
            chk_eq("lds_reg1", 32'(o_r1), 32'h1111);
            chk_eq("lds_reg2", 32'(o_r2), 32'h2222);
            chk_eq("lds_reg3", 32'(o_r3), 32'h3333);
            if (i == 3) chk_eq("lds_done", 32'(o_done), 32'd1);
            if (i < 3) tick();
        end
        Load = 1'b0;
        tick();
        chk_eq("lds_after_cnt", 32'(o_cnt), 32'd0);
        chk_eq("lds_after_reg3", 32'(o_r3), 32'h3333);

        // Clear together with Load after two words
        do_reset();
        use3 = 1'b0;
        Load = 1'b1; Data_In = 16'h1111;
        tick();
        Data_In = 16'h2222;
        tick();
        Clear = 1'b1; Data_In = 16'h3333;
        tick();
        Clear = 1'b0; Load = 1'b0;
        chk_eq("clr_cnt", 32'(o_cnt), 32'd0);
        chk_eq("clr_ready", 32'(o_ready), 32'd1);
        chk_eq("clr_reg1", 32'(o_r1), 32'h1111);
        chk_eq("clr_reg2", 32'(o_r2), 32'h2222);
        chk_eq("clr_reg3", 32'(o_r3), 32'h0000);
        chk_eq("clr_en", 32'(o_en), 32'd0);

        // Reset while Selector=2 (DWELL=1)
        do_reset();
        use3 = 1'b0;
        push_seq(1, 16'h5A5A, 16'hC3C3, 16'h0F0F);
        load3(16'h5A5A, 16'hC3C3, 16'h0F0F, 1'b0);
        tick();
        tick();
        chk_eq("rs_sel2", 32'(o_sel), 32'd2);
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_eq("rs_regs", {16'h0, o_r1 | o_r2 | o_r3}, 32'd0);
        chk_eq("rs_en", 32'(o_en), 32'd0);
        chk_eq("rs_cnt", 32'(o_cnt), 32'd0);
        chk_eq("rs_ready", 32'(o_ready), 32'd1);
        chk_eq("rs_done", 32'(o_done), 32'd0);
        repeat (3) tick();
        chk_eq("rs_no_pulse", 32'(done_cnt - d0), 32'd0);

        chk_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
